mdu32: RTL and testbench
========================

# mdu32

Iterative multiply/divide unit (HI/LO unit) for the MIPS32 datapath. Executes MULT, MULTU, DIV and DIVU in a fixed 32 cycles, and MTHI/MTLO in 1 cycle, holding results in architectural HI/LO registers. `hi`/`lo` are consumed downstream by the writeback 3:1 result mux (MFHI/MFLO path). `busy` is consumed by the pipeline stall logic.

## Interface
- No parameters; datapath width is fixed at 32.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  operation:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111: no-op.
- `src1`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `src2`  in  32  rt operand: multiplier or divisor.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  a multi-cycle operation is in progress.
- `done`  out  1  one-cycle pulse; HI/LO updated by a MULT/DIV-class op this cycle.

## Operation
- States: IDLE, RUN.
- Reset (any state): state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, 5-bit counter=0. An in-flight operation is discarded.
- IDLE, `start`=1:
  - MTHI: `hi`<=`src1` at that edge; `lo` unchanged; stay IDLE; `done` stays 0.
  - MTLO: `lo`<=`src1` at that edge; `hi` unchanged; stay IDLE; `done` stays 0.
  - MULT/MULTU/DIV/DIVU:
    - Latch operand magnitudes. Signed ops use two's-complement absolute value; 0x80000000 maps to magnitude 2^31.
    - Latch result-sign flags and op class.
    - Clear counter; go to RUN.
  - 110/111: no state change.
- RUN: one iteration per cycle for 32 cycles (counter 0..31).
  - Multiply: radix-2 shift-add of unsigned magnitudes into a 64-bit product.
  - Divide: restoring divide of unsigned magnitudes, yielding a 32-bit quotient and a 32-bit remainder.
  - On the edge where counter=31: write HI/LO, assert `done` for the following cycle, return to IDLE.
- Sign rules (signed ops only):
  - Product negated (64-bit) if operand signs differ.
  - Quotient negated if operand signs differ.
  - Remainder takes the sign of the dividend.
- Result mapping:
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
- Divide by zero (DIV or DIVU, `src2`=0): completes in 32 cycles with LO=0xFFFFFFFF, HI=`src1` (raw input value).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (the natural 32-bit truncation).
- `start` while `busy`=1 is ignored for every op, including MTHI/MTLO. HI/LO are not modified.
- `hi`/`lo` keep their old values throughout RUN; no intermediate values are visible.

## Timing
- Let E0 be the edge at which a MULT/DIV-class start is accepted.
- `busy`=1 for exactly 32 cycles, from after E0 until E32.
- At E32: `hi`/`lo` are updated and `busy` falls. `done`=1 for the one cycle after E32.
- A new start may be accepted at E33. Back-to-back throughput is 33 cycles per op.
- MTHI/MTLO latency is 1 edge. A write at edge E is visible on `hi`/`lo` in the cycle after E.
- `rst` asserted at any edge overrides `start` and any in-flight op at that edge.

## Test plan
- MULT `src1`=0xFFFFFFFD (-3), `src2`=5:
  - `busy` high for 32 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, with a 1-cycle `done` pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Repeat as MULT -> `hi`=0, `lo`=1.
- Divide results:
  - DIV 0xFFFFFFF9 (-7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7 / 0 -> `lo`=0xFFFFFFFF, `hi`=7.
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles:
  - Each takes effect one edge later.
  - `busy` and `done` remain 0.
- Start MULTU 3×4 and, during RUN, pulse `start` with MTHI 0xDEADBEEF and with DIV:
  - Both requests are ignored.
  - Final `hi`=0, `lo`=12 at E32.
- Start DIVU 100/7 and assert `rst` at cycle 10:
  - Next cycle: `busy`=0, `hi`=`lo`=0, no `done` pulse.
  - A fresh DIVU 100/7 then gives `lo`=14, `hi`=2.

Source files
------------

// File: rtl/mdu32.sv
// mdu32: iterative HI/LO multiply/divide unit for the MIPS32 datapath.
// MULT/MULTU/DIV/DIVU run for a fixed 32 cycles; MTHI/MTLO write in one edge.
//
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   synchronous active-high reset
//   start in   1   request, sampled only while busy=0
//   op    in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   src1  in  32   multiplicand / dividend / MTHI-MTLO data
//   src2  in  32   multiplier / divisor
//   hi    out 32   HI register
//   lo    out 32   LO register
//   busy  out  1   multi-cycle op in progress
//   done  out  1   one-cycle pulse after HI/LO written by a MULT/DIV-class op
module mdu32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Shared working register: multiply {partial_hi, multiplier/low product},
  // divide {remainder, dividend/quotient}.
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [W-1:0]    raw1_q, raw1_d;   // raw src1, returned as HI on divide-by-zero
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d; // negate product / quotient
  logic            neg_hi_q, neg_hi_d; // negate remainder
  logic            div0_q, div0_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Operand decode and magnitudes
  logic            is_signed_op, is_md_op, is_div_op;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;

  always_comb begin
    is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_md_op     = (op == OP_MULT) || (op == OP_MULTU) ||
                   (op == OP_DIV)  || (op == OP_DIVU);
    is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    a_neg        = is_signed_op & src1[W-1];
    b_neg        = is_signed_op & src2[W-1];
    // 0x80000000 negates to itself, which reads as 2^31 unsigned.
    a_mag        = a_neg ? (~src1 + W'(1)) : src1;
    b_mag        = b_neg ? (~src2 + W'(1)) : src2;
  end

  // One iteration of shift-add multiply and restoring divide
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    div_diff;
  logic [2*W-1:0]  div_next;
  logic [2*W-1:0]  step;
  logic [2*W-1:0]  prod_fin;
  logic [W-1:0]    quo_fin, rem_fin;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : W'(0))};
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // Remainder after a successful subtract is below the divisor, so 32 bits suffice.
    div_diff  = div_shift[W-1:0] - opb_q;
    div_next  = div_ge ? {div_diff, acc_q[W-2:0], 1'b1}
                       : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    step      = is_div_q ? div_next : mul_next;
    prod_fin  = neg_lo_q ? (~step + (2*W)'(1)) : step;
    quo_fin   = neg_lo_q ? (~step[W-1:0] + W'(1)) : step[W-1:0];
    rem_fin   = neg_hi_q ? (~step[2*W-1:W] + W'(1)) : step[2*W-1:W];
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    raw1_d   = raw1_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = src1;
          end else if (op == OP_MTLO) begin
            lo_d = src1;
          end else if (is_md_op) begin
            acc_d    = {W'(0), (is_div_op ? a_mag : b_mag)};
            opb_d    = is_div_op ? b_mag : a_mag;
            raw1_d   = src1;
            is_div_d = is_div_op;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            div0_d   = is_div_op && (src2 == W'(0));
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          if (!is_div_q) begin
            hi_d = prod_fin[2*W-1:W];
            lo_d = prod_fin[W-1:0];
          end else if (div0_q) begin
            hi_d = raw1_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fin;
            lo_d = quo_fin;
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      raw1_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      raw1_q   <= raw1_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mdu32.sv
// tb_mdu32: self-checking bench for mdu32 with directed cases and a
// randomized mix checked against an arithmetic reference of HI/LO.
module tb_mdu32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors;
  int checks;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu32 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .src1 (src1),
    .src2 (src2),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op on HI/LO, from plain arithmetic.
  function automatic void ref_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'd0: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: begin
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic do_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    logic [31:0] ph;
    logic [31:0] pl;
    ph = m_hi;
    pl = m_lo;
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_rise"}, 64'(busy), 64'(1));
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 16) begin
        check({tag, " hold_hi"}, 64'(hi), 64'(ph));
        check({tag, " hold_lo"}, 64'(lo), 64'(pl));
        check({tag, " no_done"}, 64'(done), 64'(0));
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(32));
    ref_apply(o, a, b);
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
    @(posedge clk); #1;
    check({tag, " done_fall"}, 64'(done), 64'(0));
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a, input string tag);
    logic [31:0] ph;
    logic [31:0] pl;
    ph = m_hi;
    pl = m_lo;
    @(negedge clk);
    op = o; src1 = a; start = 1'b1;
    #1;
    check({tag, " pre_hi"}, 64'(hi), 64'(ph));
    check({tag, " pre_lo"}, 64'(lo), 64'(pl));
    @(posedge clk); #1;
    start = 1'b0;
    ref_apply(o, a, 32'd0);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    errors = 0;
    checks = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    rst = 1'b1; start = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    rst = 1'b0;

    // Directed arithmetic cases
    do_md(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    check("mult_m3x5 hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
    check("mult_m3x5 lo_const", 64'(lo), 64'(32'hFFFF_FFF1));
    do_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max hi_const", 64'(hi), 64'(32'hFFFF_FFFE));
    check("multu_max lo_const", 64'(lo), 64'(32'h0000_0001));
    do_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
    check("mult_m1xm1 hi_const", 64'(hi), 64'(0));
    check("mult_m1xm1 lo_const", 64'(lo), 64'(1));
    do_md(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    check("div_m7_2 lo_const", 64'(lo), 64'(32'hFFFF_FFFD));
    check("div_m7_2 hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
    do_md(3'd3, 32'd7, 32'd0, "divu_by0");
    check("divu_by0 lo_const", 64'(lo), 64'(32'hFFFF_FFFF));
    check("divu_by0 hi_const", 64'(hi), 64'(7));
    do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf lo_const", 64'(lo), 64'(32'h8000_0000));
    check("div_ovf hi_const", 64'(hi), 64'(0));
    do_md(3'd2, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");

    // MTHI then MTLO on consecutive edges
    do_mt(3'd4, 32'h1234_5678, "mthi");
    do_mt(3'd5, 32'h9ABC_DEF0, "mtlo");

    // Requests during RUN are ignored
    @(negedge clk);
    op = 3'd1; src1 = 32'd3; src2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (5) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    op = 3'd4; src1 = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n++;
    check("busy_ign mthi hi", 64'(hi), 64'(m_hi));
    @(negedge clk);
    op = 3'd2; src1 = 32'd100; src2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n++;
    while (busy === 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    ref_apply(3'd1, 32'd3, 32'd4);
    check("busy_ign cycles", 64'(n), 64'(32));
    check("busy_ign done", 64'(done), 64'(1));
    check("busy_ign hi", 64'(hi), 64'(0));
    check("busy_ign lo", 64'(lo), 64'(12));
    @(posedge clk); #1;
    check("busy_ign no_restart", 64'(busy), 64'(0));
    check("busy_ign done_fall", 64'(done), 64'(0));

    // Reset in the middle of a divide
    @(negedge clk);
    op = 3'd3; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst hi", 64'(hi), 64'(0));
    check("midrst lo", 64'(lo), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) n++;
    end
    check("midrst quiet", 64'(n), 64'(0));
    do_md(3'd3, 32'd100, 32'd7, "divu_after_rst");
    check("divu_after_rst lo_const", 64'(lo), 64'(14));
    check("divu_after_rst hi_const", 64'(hi), 64'(2));

    // Randomized mix
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      if (ro < 3'd4) begin
        do_md(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
      end else if (ro < 3'd6) begin
        do_mt(ro, ra, $sformatf("rnd%0d_op%0d", i, ro));
      end else begin
        @(negedge clk);
        op = ro; src1 = ra; src2 = rb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("rnd%0d_nop busy", i), 64'(busy), 64'(0));
        check($sformatf("rnd%0d_nop hi", i), 64'(hi), 64'(m_hi));
        check($sformatf("rnd%0d_nop lo", i), 64'(lo), 64'(m_lo));
        check($sformatf("rnd%0d_nop done", i), 64'(done), 64'(0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
